// File: rtl/axi_slave_pkg.sv
// Shared types for the burst memory slave: response codes and channel FSM states.
package axi_slave_pkg;

    typedef logic [1:0] resp_t;

    localparam resp_t OKAY   = 2'b00;
    localparam resp_t SLVERR = 2'b10;

    typedef enum logic [1:0] {R_IDLE, R_DATA, R_GAP} rd_state_t;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP, W_GAP} wr_state_t;

    // Map an error condition onto the response code returned to the master.
    function automatic resp_t resp_of(input logic err);
        return err ? SLVERR : OKAY;
    endfunction

endpackage

// File: rtl/slave_mem_core.sv
// Simple dual-port RAM, DEPTH x DATA_W: one registered read port (read-first
// against a same-cycle write) and one write port with byte enables.
module slave_mem_core #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_en,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_W-1:0]     rd_data,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [DATA_W/8-1:0]   wr_be
);

    localparam int DEPTH = 2**ADDR_W;
    localparam int NB    = DATA_W/8;

    logic [DATA_W-1:0] mem [DEPTH];

    // Byte-masked write port.
    // NOTE: the array has no reset branch; its contents survive rst and it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < NB; b++) begin
                if (wr_be[b]) begin
                    mem[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
                end
            end
        end
    end

    // Registered read port; holds its value while rd_en is low.
    // NOTE: non-blocking assignments here and in the write block make a same-cycle read see the old word.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/axi_burst_slave_mem.sv
// Burst memory slave with independent read (AR/R) and write (AW/W/B) channels,
// a programmable post-burst gap per channel and SLVERR reporting for
// out-of-range beats and write length mismatches.
// Optional feature: define SLAVE_WSTRB_EN to add the WSTRB byte-strobe input.
module axi_burst_slave_mem
    import axi_slave_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int ID_W   = 4,
    parameter int LEN_W  = 4,
    parameter int DLY_W  = 5
) (
    input  logic                clk,
    input  logic                rst,
    // read address channel
    input  logic                ARVALID,
    output logic                ARREADY,
    input  logic [ID_W-1:0]     ARID,
    input  logic [ADDR_W:0]     ARADDR,
    input  logic [LEN_W-1:0]    ARLEN,
    // read data channel
    output logic                RVALID,
    input  logic                RREADY,
    output logic [ID_W-1:0]     RID,
    output logic [DATA_W-1:0]   RDATA,
    output logic [1:0]          RRESP,
    output logic                RLAST,
    // write address channel
    input  logic                AWVALID,
    output logic                AWREADY,
    input  logic [ID_W-1:0]     AWID,
    input  logic [ADDR_W:0]     AWADDR,
    input  logic [LEN_W-1:0]    AWLEN,
    // write data channel
    input  logic                WVALID,
    output logic                WREADY,
    input  logic [DATA_W-1:0]   WDATA,
`ifdef SLAVE_WSTRB_EN
    input  logic [DATA_W/8-1:0] WSTRB,
`endif
    input  logic                WLAST,
    // write response channel
    output logic                BVALID,
    input  logic                BREADY,
    output logic [ID_W-1:0]     BID,
    output logic [1:0]          BRESP,
    // misc
    input  logic [DLY_W-1:0]    DELAY,
    output logic                RIDLE,
    output logic                WIDLE
);

    localparam int NB  = DATA_W/8;
    localparam int AW2 = ADDR_W + 2;   // one spare bit so ADDR + beat never wraps

    // ---------------- read channel state ----------------
    rd_state_t          r_state;
    logic [ADDR_W:0]    r_addr;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_beat;
    logic [DLY_W-1:0]   r_dly;
    logic [DLY_W-1:0]   r_gap;
    logic               r_oor;
    logic [AW2-1:0]     r_next_addr;
    logic               r_next_oor;
    logic               ar_hs;
    logic               r_hs;

    // ---------------- write channel state ----------------
    wr_state_t          w_state;
    logic [ID_W-1:0]    w_id;
    logic [ADDR_W:0]    w_addr;
    logic [LEN_W-1:0]   w_len;
    logic [LEN_W:0]     w_beat;       // one extra bit to survive overlong bursts
    logic [DLY_W-1:0]   w_dly;
    logic [DLY_W-1:0]   w_gap;
    logic               w_err;
    logic [AW2-1:0]     w_cur_addr;
    logic               w_cur_oor;
    logic               aw_hs;
    logic               w_hs;

    // ---------------- memory ports ----------------
    logic                mem_rd_en;
    logic [ADDR_W-1:0]   mem_rd_addr;
    logic [DATA_W-1:0]   mem_rd_data;
    logic                mem_wr_en;
    logic [ADDR_W-1:0]   mem_wr_addr;
    logic [NB-1:0]       mem_wr_be;

    assign ar_hs = ARVALID && ARREADY;
    assign r_hs  = RVALID && RREADY;
    assign aw_hs = AWVALID && AWREADY;
    assign w_hs  = WVALID && WREADY;

    assign r_next_addr = {1'b0, r_addr} + AW2'(r_beat) + AW2'(1);
    assign r_next_oor  = (r_next_addr[AW2-1:ADDR_W] != 2'b00);
    assign w_cur_addr  = {1'b0, w_addr} + AW2'(w_beat);
    assign w_cur_oor   = (w_cur_addr[AW2-1:ADDR_W] != 2'b00);

    assign RIDLE = (r_state == R_IDLE);
    assign WIDLE = (w_state == W_IDLE);

    // Out-of-range beats return zero regardless of what the RAM port holds.
    assign RDATA = r_oor ? '0 : mem_rd_data;

    // Fetch beat 0 on the AR handshake and each following beat on an R handshake.
    assign mem_rd_en   = !rst && (((r_state == R_IDLE) && ar_hs) ||
                                  ((r_state == R_DATA) && r_hs && !RLAST));
    assign mem_rd_addr = (r_state == R_IDLE) ? ARADDR[ADDR_W-1:0] : r_next_addr[ADDR_W-1:0];

    // Write port: only in-range beats of an active burst reach the RAM.
    // NOTE: every output of this always_comb gets a default first, so no latch is inferred.
    always_comb begin
        mem_wr_en   = 1'b0;
        mem_wr_addr = w_cur_addr[ADDR_W-1:0];
        if (!rst && (w_state == W_DATA) && w_hs && !w_cur_oor) begin
            mem_wr_en = 1'b1;
        end
`ifdef SLAVE_WSTRB_EN
        mem_wr_be = WSTRB;
`else
        mem_wr_be = '1;
`endif
    end

    slave_mem_core #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .rd_en   (mem_rd_en),
        .rd_addr (mem_rd_addr),
        .rd_data (mem_rd_data),
        .wr_en   (mem_wr_en),
        .wr_addr (mem_wr_addr),
        .wr_data (WDATA),
        .wr_be   (mem_wr_be)
    );

    // Read FSM: accept AR, stream LEN+1 beats, then wait out the gap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= R_IDLE;
            ARREADY <= 1'b0;
            RVALID  <= 1'b0;
            RLAST   <= 1'b0;
            RRESP   <= OKAY;
            RID     <= '0;
            r_oor   <= 1'b0;
            r_addr  <= '0;
            r_len   <= '0;
            r_beat  <= '0;
            r_dly   <= '0;
            r_gap   <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    ARREADY <= 1'b1;
                    if (ar_hs) begin
                        ARREADY <= 1'b0;
                        RID     <= ARID;
                        r_addr  <= ARADDR;
                        r_len   <= ARLEN;
                        r_dly   <= DELAY;
                        r_beat  <= '0;
                        RVALID  <= 1'b1;
                        RLAST   <= (ARLEN == '0);
                        RRESP   <= resp_of(ARADDR[ADDR_W]);
                        r_oor   <= ARADDR[ADDR_W];
                        r_state <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (r_hs) begin
                        if (RLAST) begin
                            RVALID <= 1'b0;
                            RLAST  <= 1'b0;
                            RRESP  <= OKAY;
                            r_oor  <= 1'b0;
                            if (r_dly == '0) begin
                                ARREADY <= 1'b1;
                                r_state <= R_IDLE;
                            end else begin
                                r_gap   <= r_dly;
                                r_state <= R_GAP;
                            end
                        end else begin
                            r_beat <= r_beat + LEN_W'(1);
                            RLAST  <= ((r_beat + LEN_W'(1)) == r_len);
                            RRESP  <= resp_of(r_next_oor);
                            r_oor  <= r_next_oor;
                        end
                    end
                end
                R_GAP: begin
                    if (r_gap == DLY_W'(1)) begin
                        ARREADY <= 1'b1;
                        r_state <= R_IDLE;
                    end else begin
                        r_gap <= r_gap - DLY_W'(1);
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    // Write FSM: accept AW, absorb beats up to WLAST, answer on B, then wait out the gap.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_state <= W_IDLE;
            AWREADY <= 1'b0;
            WREADY  <= 1'b0;
            BVALID  <= 1'b0;
            BID     <= '0;
            BRESP   <= OKAY;
            w_id    <= '0;
            w_addr  <= '0;
            w_len   <= '0;
            w_beat  <= '0;
            w_dly   <= '0;
            w_gap   <= '0;
            w_err   <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    AWREADY <= 1'b1;
                    if (aw_hs) begin
                        AWREADY <= 1'b0;
                        WREADY  <= 1'b1;
                        w_id    <= AWID;
                        w_addr  <= AWADDR;
                        w_len   <= AWLEN;
                        w_dly   <= DELAY;
                        w_beat  <= '0;
                        w_err   <= 1'b0;
                        w_state <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_hs) begin
                        if (WLAST) begin
                            WREADY  <= 1'b0;
                            BVALID  <= 1'b1;
                            BID     <= w_id;
                            BRESP   <= resp_of(w_err || w_cur_oor || (w_beat != {1'b0, w_len}));
                            w_state <= W_RESP;
                        end else begin
                            w_beat <= w_beat + (LEN_W+1)'(1);
                            // a non-final beat at or past index LEN means too many beats
                            if (w_cur_oor || (w_beat >= {1'b0, w_len})) begin
                                w_err <= 1'b1;
                            end
                        end
                    end
                end
                W_RESP: begin
                    if (BVALID && BREADY) begin
                        BVALID <= 1'b0;
                        if (w_dly == '0) begin
                            AWREADY <= 1'b1;
                            w_state <= W_IDLE;
                        end else begin
                            w_gap   <= w_dly;
                            w_state <= W_GAP;
                        end
                    end
                end
                W_GAP: begin
                    if (w_gap == DLY_W'(1)) begin
                        AWREADY <= 1'b1;
                        w_state <= W_IDLE;
                    end else begin
                        w_gap <= w_gap - DLY_W'(1);
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

endmodule
